// File: rtl/addr_cal_pkg.sv
// Shared types and constant helpers for the multistream read address generator.
package addr_cal_pkg;

    localparam int unsigned DEF_CH_SPAN_LOG2 = 32'd28;
    localparam int unsigned DEF_ALIGN_LOG2   = 32'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CALC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int unsigned stream_shift(input int unsigned streams);
        return $clog2(streams);
    endfunction

    function automatic int unsigned ch_index(input int unsigned ch,
                                             input int unsigned parity,
                                             input int unsigned offset);
        return 32'd2 * ch + parity + offset;
    endfunction

endpackage

// File: rtl/addr_cal_read_multistream_ch_base_calc.sv
// Registered base address of one logical channel: the masked pointer plus the
// span-aligned offset of its physical channel (2*i + parity + CHANNEL_OFFSET).
module ch_base_calc
    import addr_cal_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32'd64,
    parameter int unsigned CHANNEL_INDEX  = 32'd0,
    parameter int unsigned CHANNEL_OFFSET = 32'd0,
    parameter int unsigned CH_SPAN_LOG2   = DEF_CH_SPAN_LOG2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_parity,
    input  logic [ADDR_W-1:0] i_ptr,
    output logic [ADDR_W-1:0] o_base
);

    localparam int unsigned       EVEN_IDX = ch_index(CHANNEL_INDEX, 32'd0, CHANNEL_OFFSET);
    localparam logic [ADDR_W-1:0] HI_MASK  = {ADDR_W{1'b1}} << CH_SPAN_LOG2;

    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] r_base;

    assign w_offset = (ADDR_W'(EVEN_IDX) + ADDR_W'(i_parity)) << CH_SPAN_LOG2;
    assign w_base   = (i_ptr & HI_MASK) + w_offset;

    // Capture the channel base during the request check cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= {ADDR_W{1'b0}};
        end else if (i_load) begin
            r_base <= w_base;
        end else begin
            r_base <= r_base;
        end
    end

    assign o_base = r_base;

endmodule

// File: rtl/addr_cal_read_multistream.sv
// Phase-2 read address generator: validates a request, then builds the start
// addresses of every stream of every channel with a sequential accumulator.
module addr_cal_read_multistream
    import addr_cal_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32'd64,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32'd64,
    parameter int unsigned CHANNEL_OFFSET     = 32'd0,
    parameter int unsigned NUM_CH             = 32'd4,
    parameter int unsigned STREAMS_PER_CH     = 32'd4,
    parameter int unsigned CH_SPAN_LOG2       = DEF_CH_SPAN_LOG2,
    parameter int unsigned ALIGN_LOG2         = DEF_ALIGN_LOG2
) (
    input  logic                                                     aclk,
    input  logic                                                     ap_rst_n,
    input  logic                                                     i_start,
    input  logic                                                     i_pass_parity,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]                            i_ptr_ch_0,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                             i_xfer_size_in_bytes,
    output logic                                                     o_busy,
    output logic                                                     o_read_start,
    output logic [NUM_CH*STREAMS_PER_CH-1:0][C_M_AXI_ADDR_WIDTH-1:0] o_read_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]                             o_read_size_in_bytes,
    output logic                                                     o_err
);

    localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned XW    = C_XFER_SIZE_WIDTH;
    localparam int unsigned NS    = NUM_CH * STREAMS_PER_CH;
    localparam int unsigned SHIFT = stream_shift(STREAMS_PER_CH);
    localparam int unsigned CHK_W = SHIFT + ALIGN_LOG2;
    localparam int unsigned K_W   = (SHIFT == 32'd0) ? 32'd1 : SHIFT;
    localparam logic [XW-1:0] SPAN_LIMIT = XW'(1) << CH_SPAN_LOG2;

    state_t                       r_state;
    logic                         r_parity;
    logic [AW-1:0]                r_ptr;
    logic [XW-1:0]                r_size;
    logic [XW-1:0]                r_stream_size;
    logic [CH_SPAN_LOG2-1:0]      r_acc;
    logic [K_W-1:0]               r_k;
    logic [NS-1:0][AW-1:0]        r_bank;
    logic [NS-1:0][AW-1:0]        r_read_addr;
    logic [XW-1:0]                r_read_size;
    logic                         r_busy;
    logic                         r_read_start;
    logic                         r_err;

    logic [AW-1:0]                w_base [NUM_CH];
    logic [NS-1:0][AW-1:0]        w_bank_val;
    logic [NS-1:0]                w_bank_wr;
    logic                         w_illegal;
    logic                         w_load_base;

    assign w_load_base = (r_state == CHECK);
    assign w_illegal   = (r_size[CHK_W-1:0] != CHK_W'(0)) || (r_size >= SPAN_LIMIT);

    for (genvar g_ch = 0; g_ch < NUM_CH; g_ch++) begin : g_base
        ch_base_calc #(
            .ADDR_W         (AW),
            .CHANNEL_INDEX  (g_ch),
            .CHANNEL_OFFSET (CHANNEL_OFFSET),
            .CH_SPAN_LOG2   (CH_SPAN_LOG2)
        ) u_ch_base_calc (
            .clk      (aclk),
            .rst_n    (ap_rst_n),
            .i_load   (w_load_base),
            .i_parity (r_parity),
            .i_ptr    (r_ptr),
            .o_base   (w_base[g_ch])
        );
    end

    // Base low bits are zero, so OR-ing in the accumulator forms the stream address.
    for (genvar g_j = 0; g_j < NS; g_j++) begin : g_bank
        localparam int unsigned CH = g_j / STREAMS_PER_CH;
        localparam int unsigned KK = g_j % STREAMS_PER_CH;
        assign w_bank_val[g_j] = w_base[CH] | AW'(r_acc);
        assign w_bank_wr[g_j]  = (r_state == CALC) && (r_k == K_W'(KK));
    end

    // Request FSM: accept, check, accumulate stream offsets, publish the bank.
    always_ff @(posedge aclk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= IDLE;
            r_parity      <= 1'b0;
            r_ptr         <= {AW{1'b0}};
            r_size        <= {XW{1'b0}};
            r_stream_size <= {XW{1'b0}};
            r_acc         <= {CH_SPAN_LOG2{1'b0}};
            r_k           <= {K_W{1'b0}};
            r_bank        <= '0;
            r_read_addr   <= '0;
            r_read_size   <= {XW{1'b0}};
            r_busy        <= 1'b0;
            r_read_start  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_read_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_parity <= i_pass_parity;
                        r_ptr    <= i_ptr_ch_0;
                        r_size   <= i_xfer_size_in_bytes;
                        r_busy   <= 1'b1;
                        r_err    <= 1'b0;
                        r_state  <= CHECK;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                CHECK: begin
                    if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_stream_size <= r_size >> SHIFT;
                        r_acc         <= {CH_SPAN_LOG2{1'b0}};
                        r_k           <= {K_W{1'b0}};
                        r_state       <= CALC;
                    end
                end
                CALC: begin
                    for (int j = 0; j < NS; j++) begin
                        if (w_bank_wr[j]) begin
                            r_bank[j] <= w_bank_val[j];
                        end else begin
                            r_bank[j] <= r_bank[j];
                        end
                    end
                    r_acc <= r_acc + r_stream_size[CH_SPAN_LOG2-1:0];
                    r_k   <= r_k + K_W'(1);
                    if (r_k == K_W'(STREAMS_PER_CH - 32'd1)) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= CALC;
                    end
                end
                DONE: begin
                    r_read_start <= 1'b1;
                    r_read_addr  <= r_bank;
                    r_read_size  <= r_stream_size;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy               = r_busy;
    assign o_read_start         = r_read_start;
    assign o_read_addr          = r_read_addr;
    assign o_read_size_in_bytes = r_read_size;
    assign o_err                = r_err;

endmodule

// File: tb/tb_addr_cal_read_multistream.sv
// Directed bench for addr_cal_read_multistream: default 4x4 instance plus a 2x8 instance.
module tb_addr_cal_read_multistream;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_start = 1'b0;
    logic              a_par = 1'b0;
    logic [63:0]       a_ptr = 64'h0;
    logic [63:0]       a_size = 64'h0;
    logic              a_busy, a_rs, a_err;
    logic [15:0][63:0] a_addr;
    logic [63:0]       a_osize;

    logic              b_start = 1'b0;
    logic              b_busy, b_rs, b_err;
    logic [15:0][63:0] b_addr;
    logic [63:0]       b_osize;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] PTR = 64'h0000_0040_0000_0000;

    always #5 clk = ~clk;

    addr_cal_read_multistream u_dut_a (
        .aclk                 (clk),
        .ap_rst_n             (rst_n),
        .i_start              (a_start),
        .i_pass_parity        (a_par),
        .i_ptr_ch_0           (a_ptr),
        .i_xfer_size_in_bytes (a_size),
        .o_busy               (a_busy),
        .o_read_start         (a_rs),
        .o_read_addr          (a_addr),
        .o_read_size_in_bytes (a_osize),
        .o_err                (a_err)
    );

    addr_cal_read_multistream #(.NUM_CH(32'd2), .STREAMS_PER_CH(32'd8)) u_dut_b (
        .aclk                 (clk),
        .ap_rst_n             (rst_n),
        .i_start              (b_start),
        .i_pass_parity        (1'b0),
        .i_ptr_ch_0           (PTR),
        .i_xfer_size_in_bytes (64'h0000_0000_0000_8000),
        .o_busy               (b_busy),
        .o_read_start         (b_rs),
        .o_read_addr          (b_addr),
        .o_read_size_in_bytes (b_osize),
        .o_err                (b_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on instance A; reports latency, pulse count and flags.
    task automatic run_a(input logic par, input logic [63:0] size,
                         output int first, output int cnt,
                         output logic busy0, output logic err0, output logic err1);
        a_par   = par;
        a_ptr   = PTR;
        a_size  = size;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        busy0 = a_busy;
        err0  = a_err;
        err1  = 1'b0;
        first = -1;
        cnt   = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) err1 = a_err;
            if (a_rs) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
    endtask

    initial begin
        int   first, cnt, p1, p2;
        logic busy0, err0, err1;

        tick();
        tick();
        chk("rst_busy",  64'(a_busy),  64'h0);
        chk("rst_start", 64'(a_rs),    64'h0);
        chk("rst_err",   64'(a_err),   64'h0);
        chk("rst_addr0", a_addr[0],    64'h0);
        chk("rst_addr15", a_addr[15],  64'h0);
        chk("rst_size",  a_osize,      64'h0);
        rst_n = 1'b1;
        tick();

        run_a(1'b0, 64'h0100_0000, first, cnt, busy0, err0, err1);
        chk("p0_busy_rise", 64'(busy0), 64'h1);
        chk("p0_latency",   64'(first), 64'd6);
        chk("p0_pulses",    64'(cnt),   64'd1);
        chk("p0_addr0",  a_addr[0],  64'h0000_0040_0000_0000);
        chk("p0_addr5",  a_addr[5],  64'h0000_0040_2040_0000);
        chk("p0_addr15", a_addr[15], 64'h0000_0040_60C0_0000);
        chk("p0_size",   a_osize,    64'h0000_0000_0040_0000);
        chk("p0_busy_end", 64'(a_busy), 64'h0);

        run_a(1'b1, 64'h0100_0000, first, cnt, busy0, err0, err1);
        chk("p1_latency", 64'(first), 64'd6);
        chk("p1_addr0",   a_addr[0],  64'h0000_0040_1000_0000);
        chk("p1_addr6",   a_addr[6],  64'h0000_0040_3080_0000);

        run_a(1'b0, 64'h0100_0020, first, cnt, busy0, err0, err1);
        chk("unal_err",    64'(err1),  64'h1);
        chk("unal_busy",   64'(a_busy), 64'h0);
        chk("unal_pulses", 64'(cnt),   64'd0);
        chk("unal_addr6",  a_addr[6],  64'h0000_0040_3080_0000);

        run_a(1'b0, 64'h1000_0000, first, cnt, busy0, err0, err1);
        chk("span_err",    64'(err1),  64'h1);
        chk("span_pulses", 64'(cnt),   64'd0);
        chk("span_addr0",  a_addr[0],  64'h0000_0040_1000_0000);

        run_a(1'b0, 64'h0, first, cnt, busy0, err0, err1);
        chk("clr_err",     64'(err0),  64'h0);
        chk("zero_latency", 64'(first), 64'd6);
        chk("zero_addr7",  a_addr[7],  64'h0000_0040_2000_0000);
        chk("zero_size",   a_osize,    64'h0);

        // i_start held for ten edges: only the first and post-DONE starts land
        a_par = 1'b0; a_size = 64'h0100_0000; a_start = 1'b1;
        cnt = 0; p1 = -1; p2 = -1;
        for (int n = 1; n <= 25; n++) begin
            tick();
            if (n == 10) a_start = 1'b0;
            if (a_rs) begin
                cnt++;
                if (p1 < 0) p1 = n;
                else if (p2 < 0) p2 = n;
            end
        end
        chk("b2b_pulses", 64'(cnt), 64'd2);
        chk("b2b_first",  64'(p1),  64'd7);
        chk("b2b_second", 64'(p2),  64'd14);

        // reset in the middle of CALC
        a_par = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(a_busy), 64'h0);
        chk("mid_rst_addr0", a_addr[0],   64'h0);
        chk("mid_rst_size",  a_osize,     64'h0);
        cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 2) rst_n = 1'b1;
            if (a_rs) cnt++;
        end
        chk("mid_rst_pulses", 64'(cnt), 64'd0);
        run_a(1'b0, 64'h0100_0000, first, cnt, busy0, err0, err1);
        chk("post_rst_latency", 64'(first), 64'd6);
        chk("post_rst_addr5",   a_addr[5],  64'h0000_0040_2040_0000);

        // 2 channels x 8 streams
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        first = -1; cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (b_rs) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        chk("b_latency", 64'(first), 64'd10);
        chk("b_pulses",  64'(cnt),   64'd1);
        chk("b_size",    b_osize,    64'h0000_0000_0000_1000);
        chk("b_addr7",   b_addr[7],  64'h0000_0040_0000_7000);
        chk("b_addr15",  b_addr[15], 64'h0000_0040_2000_7000);
        chk("b_err",     64'(b_err), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addr_cal_read_multistream.md
Name: addr_cal_read_multistream

Overview:
Parametrised phase-2 read address generator for merge trees in any SLR. It produces start addresses for NUM_CH read channels, each split into STREAMS_PER_CH equal consecutive streams, plus a common per-stream byte size. The channel is chosen by pass parity. Stream offsets are accumulated sequentially, so no multipliers are used. Output is a registered address bank that is presented with a one-cycle start pulse. The block sits between the kernel control FSM and the per-tree AXI read masters.

Parameters:
C_M_AXI_ADDR_WIDTH, 64, AXI address width
C_XFER_SIZE_WIDTH, 64, width of the size inputs and outputs
CHANNEL_OFFSET, 0, HBM channel index of physical channel 0 for this instance
NUM_CH, 4, number of read channels used; the physical channel index is 2*i+parity
STREAMS_PER_CH, 4, streams per channel; must be a power of 2, minimum 1
CH_SPAN_LOG2, 28, log2 of the byte span of one channel (256MB)
ALIGN_LOG2, 6, log2 of the required stream alignment in bytes (64B beat)

Ports:
aclk, in, 1, clock
ap_rst_n, in, 1, asynchronous active-low reset
i_start, in, 1, single-cycle request to compute a new address set
i_pass_parity, in, 1, selects the even (0) or odd (1) physical channel of each pair
i_ptr_ch_0, in, C_M_AXI_ADDR_WIDTH, base address of physical channel 0
i_xfer_size_in_bytes, in, C_XFER_SIZE_WIDTH, bytes per channel
o_busy, out, 1, computation in progress; i_start is ignored while high
o_read_start, out, 1, one-cycle pulse: the address set is valid
o_read_addr, out, NUM_CH*STREAMS_PER_CH x C_M_AXI_ADDR_WIDTH, stream start addresses; index = ch*STREAMS_PER_CH+k
o_read_size_in_bytes, out, C_XFER_SIZE_WIDTH, bytes per stream
o_err, out, 1, sticky flag: the last accepted request was illegal

Behaviour:
- Reset (asynchronous, ap_rst_n low) clears everything immediately:
  - o_busy=0, o_read_start=0, o_err=0, all o_read_addr=0, o_read_size_in_bytes=0.
  - FSM goes to IDLE; the counter and accumulator are cleared.
  - Reset asserted mid-CALC aborts the computation with no start pulse.
- FSM states: IDLE, CHECK, CALC, DONE.
- IDLE:
  - When i_start=1, latch parity, pointer and size, then go to CHECK. o_busy rises on the next edge.
  - o_err is cleared on the accepting edge.
- CHECK (1 cycle): the request is illegal if either condition holds:
  - size[log2(STREAMS_PER_CH)+ALIGN_LOG2-1:0] != 0 (stream not aligned), or
  - size >= 2^CH_SPAN_LOG2 (exceeds the channel span).
  - Illegal: set o_err=1, o_busy=0, return to IDLE, no start pulse, outputs keep their previous values.
  - Legal: compute stream_size = size >> log2(STREAMS_PER_CH), clear accumulator acc=0 and counter k=0, go to CALC.
- Channel base for channel i:
  - chan_base[i] = ptr + ((2*i + parity + CHANNEL_OFFSET) << CH_SPAN_LOG2).
  - This is computed in CHECK and registered.
  - The low CH_SPAN_LOG2 bits of ptr are treated as zero, i.e. masked.
- CALC, one stream index k per cycle for all channels in parallel:
  - addr[i*S+k] = {chan_base[i][ADDR-1:CH_SPAN_LOG2], acc[CH_SPAN_LOG2-1:0]}.
  - Then acc += stream_size and k++.
  - When k == STREAMS_PER_CH-1 is written, go to DONE.
- DONE (1 cycle):
  - Drive o_read_start=1, copy the working bank to the o_read_addr registers, o_read_size_in_bytes=stream_size, o_busy=0, return to IDLE.
- Latency: i_start accepted at edge t gives o_read_start high in the cycle after edge t+STREAMS_PER_CH+2.
  - With the defaults, that is 6 cycles after i_start.
  - Outputs are held stable until the next DONE.
- An i_start arriving while busy is dropped silently. An i_start in the same cycle as DONE is also dropped.
- A back-to-back start on the cycle after DONE is accepted.
- Size 0 is legal: all streams of a channel equal its chan_base and the stream size is 0.
- STREAMS_PER_CH=1: CALC lasts 1 cycle and the alignment check uses ALIGN_LOG2 bits only.
- All arithmetic is unsigned. acc never overflows CH_SPAN_LOG2 bits because of the span check.

Decomposition:
- Package addr_cal_pkg holds:
  - localparam functions: clog2-based stream shift, channel-index helper.
  - typedef enum state_t {IDLE, CHECK, CALC, DONE}.
  - the default CH_SPAN_LOG2 and ALIGN_LOG2 constants.
- One sub-module, ch_base_calc: per-channel registered base computation with parameter CHANNEL_INDEX. It is instantiated NUM_CH times via generate and has 1-cycle latency, matching CHECK.

Test Plan:
- Defaults, ptr=0x0000_0040_0000_0000, size=0x0100_0000, parity=0, CHANNEL_OFFSET=0, start at t:
  - o_read_start is high exactly at t+6.
  - addr[5]=0x0000_0040_2040_0000.
  - addr[15]=0x0000_0040_60C0_0000.
  - size_out=0x0040_0000.
- Same request with parity=1: addr[0]=0x0000_0040_1000_0000 and addr[6]=0x0000_0040_3080_0000.
- Illegal requests with size=0x0100_0020 and with size=0x1000_0000:
  - o_err=1 two cycles after start.
  - No o_read_start; prior addresses unchanged.
  - A following legal start clears o_err.
- i_start pulsed every cycle for 10 cycles: only starts at t and at the cycle after the first DONE are accepted; exactly one start pulse per accepted request.
- ap_rst_n low during CALC (cycle t+3): all outputs are 0 immediately and no start pulse occurs. A start after release completes normally.
- NUM_CH=2, STREAMS_PER_CH=8, size=0x0000_8000: stream_size=0x1000, addr[7] low bits=0x7000, o_read_start at t+10.
